router_stream_checker: RTL

Reader/consumer end of the router test-packet stream: accepts 11-bit words on a valid/ready link from a router output port and checks them against the generator format. That format is payload [9:0] incrementing by 1 per word (mod 1024), with tail flag [10] set on every PKT_LEN-th word. It counts words, packets and errors and captures the first bad word, for FPGA self-test and bench scoreboarding.

---
 rtl/router_stream_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/router_stream_checker.sv
// Consumer end of the router test-packet stream: checks incrementing payloads and the
// tail framing, and keeps counters plus a capture of the first bad word. Macro RSC_THROTTLE_EN adds LFSR backpressure.
module router_stream_checker #(
    parameter int PKT_LEN = 6,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [10:0]      in_data,
    output logic             in_ready,
    output logic             locked,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [10:0]      first_err_word,
    output logic [10:0]      first_err_expected
);

    localparam logic [3:0] LAST_POS = 4'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_r;
    logic [9:0] expected_r;
    logic [3:0] pos_r;

    logic       transfer_s;
    logic       rx_tail_s;
    logic [9:0] rx_payload_s;
    logic [9:0] rx_next_s;
    logic       exp_tail_s;
    logic       pass_s;
    logic [3:0] pos_step_s;
    logic       ready_next_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

`ifdef RSC_THROTTLE_EN
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;

    // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else if (clear) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end
`endif

    // Decode of the incoming word against the current expectation
    always_comb begin
        transfer_s   = in_valid & in_ready;
        rx_tail_s    = in_data[10];
        rx_payload_s = in_data[9:0];
        rx_next_s    = rx_payload_s + 10'd1;
        exp_tail_s   = (pos_r == LAST_POS);
        pass_s       = (rx_payload_s == expected_r) && (rx_tail_s == exp_tail_s);
        if (exp_tail_s) begin
            pos_step_s = 4'd0;
        end else begin
            pos_step_s = pos_r + 4'd1;
        end
`ifdef RSC_THROTTLE_EN
        lfsr_fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        ready_next_s = enable & ~clear & lfsr_r[0];
`else
        ready_next_s = enable & ~clear;
`endif
    end

    // Registered ready so there is no path from in_valid back to in_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= ready_next_s;
        end
    end

    // Framing state machine, counters and first-error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r            <= HUNT;
            expected_r         <= 10'd0;
            pos_r              <= 4'd0;
            locked             <= 1'b0;
            word_count         <= '0;
            pkt_count          <= '0;
            err_count          <= '0;
            err_flag           <= 1'b0;
            first_err_word     <= 11'd0;
            first_err_expected <= 11'd0;
        end else if (clear) begin
            state_r            <= HUNT;
            expected_r         <= 10'd0;
            pos_r              <= 4'd0;
            locked             <= 1'b0;
            word_count         <= '0;
            pkt_count          <= '0;
            err_count          <= '0;
            err_flag           <= 1'b0;
            first_err_word     <= 11'd0;
            first_err_expected <= 11'd0;
        end else if (transfer_s) begin
            word_count <= sat_inc(word_count);
            case (state_r)
                HUNT: begin
                    if (rx_tail_s) begin
                        expected_r <= rx_next_s;
                        pos_r      <= 4'd0;
                        state_r    <= LOCKED;
                        locked     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (pass_s) begin
                        expected_r <= expected_r + 10'd1;
                        pos_r      <= pos_step_s;
                        if (rx_tail_s) begin
                            pkt_count <= sat_inc(pkt_count);
                        end
                    end else begin
                        err_count <= sat_inc(err_count);
                        if (!err_flag) begin
                            err_flag           <= 1'b1;
                            first_err_word     <= in_data;
                            first_err_expected <= {exp_tail_s, expected_r};
                        end
                        // Resynchronise on what was actually received
                        expected_r <= rx_next_s;
                        pos_r      <= rx_tail_s ? 4'd0 : pos_step_s;
                    end
                end
                default: begin
                    state_r <= HUNT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
